// File: rtl/out_buffer_vc_pkg.sv
// Shared defaults, arbiter state type and small index helpers for the
// virtual-channel output buffer.
package out_buffer_vc_pkg;

    localparam int DEFAULT_FLIT_WIDTH           = 80;
    localparam int DEFAULT_NUM_VC               = 2;
    localparam int DEFAULT_OUT_BUFFER_DEPTH     = 6;
    localparam int DEFAULT_LOG_OUT_BUFFER_DEPTH = 3;
    localparam int DEFAULT_TAIL_BIT             = 79;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int vcWidth(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

    // Modular increment that stays correct when the limit is not a power of two.
    function automatic int wrapInc(input int value, input int limit);
        return (value + 1 >= limit) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/out_buffer_vc_fifo.sv
// Circular per-VC flit FIFO; an empty FIFO forwards the incoming flit so a
// fresh write can reach the output register in the same cycle.
module flit_fifo
    import out_buffer_vc_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int DEPTH      = DEFAULT_OUT_BUFFER_DEPTH,
    parameter int LOG_DEPTH  = DEFAULT_LOG_OUT_BUFFER_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [FLIT_WIDTH-1:0] din_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [FLIT_WIDTH-1:0] head_o,
    output logic                  avail_o,
    output logic                  full_o
);

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [LOG_DEPTH-1:0]  rdPtr_q, rdPtr_d;
    logic [LOG_DEPTH-1:0]  wrPtr_q, wrPtr_d;
    logic [LOG_DEPTH-1:0]  count_q, count_d;
    logic                  empty;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == LOG_DEPTH'(DEPTH));
    assign avail_o = !empty || push_i;
    assign head_o  = empty ? din_i : mem_q[rdPtr_q];

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = LOG_DEPTH'(wrapInc(int'(wrPtr_q), DEPTH));
        end
        if (pop_i) begin
            rdPtr_d = LOG_DEPTH'(wrapInc(int'(rdPtr_q), DEPTH));
        end
        if (push_i && !pop_i) begin
            count_d = count_q + LOG_DEPTH'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - LOG_DEPTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the cleared count makes every stale entry unreachable.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

endmodule

// File: rtl/out_buffer_vc.sv
// Virtual-channel output buffer: per-VC FIFOs, a packet-locking round-robin
// arbiter and a single link output register.
module out_buffer_vc
    import out_buffer_vc_pkg::*;
#(
    parameter int FLIT_WIDTH           = DEFAULT_FLIT_WIDTH,
    parameter int NUM_VC               = DEFAULT_NUM_VC,
    parameter int OUT_BUFFER_DEPTH     = DEFAULT_OUT_BUFFER_DEPTH,
    parameter int LOG_OUT_BUFFER_DEPTH = DEFAULT_LOG_OUT_BUFFER_DEPTH,
    parameter int TAIL_BIT             = DEFAULT_TAIL_BIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_WIDTH-1:0]        data_in,
    input  logic                         write,
    input  logic [vcWidth(NUM_VC)-1:0]   vc_in,
    output logic [NUM_VC-1:0]            full,
    output logic                         overflow_err,
    output logic [FLIT_WIDTH-1:0]        FLIT_out,
    output logic                         VALID_out,
    output logic [vcWidth(NUM_VC)-1:0]   VC_out,
    input  logic [NUM_VC-1:0]            STALL_in
);

    localparam int VC_W = vcWidth(NUM_VC);

    logic [NUM_VC-1:0]     push, pop, avail;
    logic [FLIT_WIDTH-1:0] head [NUM_VC];

    arb_state_e            state_q, state_d;
    logic [VC_W-1:0]       lockVc_q, lockVc_d;
    logic [VC_W-1:0]       rr_q, rr_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [VC_W-1:0]       vcOut_q, vcOut_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    logic                  stallOut, loadEn, grantValid;
    logic [VC_W-1:0]       grantVc;
    logic [FLIT_WIDTH-1:0] grantFlit;

    always_comb begin
        push       = '0;
        overflow_d = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (write && !rst && (vc_in == VC_W'(v))) begin
                if (full[v]) begin
                    overflow_d = 1'b1;
                end else begin
                    push[v] = 1'b1;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : gVc
        flit_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (OUT_BUFFER_DEPTH),
            .LOG_DEPTH  (LOG_OUT_BUFFER_DEPTH)
        ) uFifo (
            .clk_i   (clk),
            .rst_i   (rst),
            .din_i   (data_in),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .head_o  (head[v]),
            .avail_o (avail[v]),
            .full_o  (full[v])
        );
    end

    // Round-robin scans VCs at or above rr_q first, then wraps to the low ones.
    always_comb begin
        stallOut   = 1'b0;
        grantValid = 1'b0;
        grantVc    = '0;
        grantFlit  = '0;
        pop        = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (vcOut_q == VC_W'(v)) begin
                stallOut = STALL_in[v];
            end
        end
        loadEn = !valid_q || !stallOut;

        if (state_q == ARB_LOCKED) begin
            grantVc = lockVc_q;
            for (int v = 0; v < NUM_VC; v++) begin
                if ((lockVc_q == VC_W'(v)) && avail[v]) begin
                    grantValid = 1'b1;
                end
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (!grantValid && avail[v] && !STALL_in[v] && (VC_W'(v) >= rr_q)) begin
                    grantValid = 1'b1;
                    grantVc    = VC_W'(v);
                end
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (!grantValid && avail[v] && !STALL_in[v]) begin
                    grantValid = 1'b1;
                    grantVc    = VC_W'(v);
                end
            end
        end

        for (int v = 0; v < NUM_VC; v++) begin
            if (grantVc == VC_W'(v)) begin
                grantFlit = head[v];
                pop[v]    = loadEn && grantValid;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lockVc_d = lockVc_q;
        rr_d     = rr_q;
        flit_d   = flit_q;
        vcOut_d  = vcOut_q;
        valid_d  = valid_q;
        if (loadEn) begin
            valid_d = grantValid;
            if (grantValid) begin
                flit_d  = grantFlit;
                vcOut_d = grantVc;
                if (grantFlit[TAIL_BIT]) begin
                    state_d = ARB_IDLE;
                    rr_d    = VC_W'(wrapInc(int'(grantVc), NUM_VC));
                end else begin
                    state_d  = ARB_LOCKED;
                    lockVc_d = grantVc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            lockVc_q   <= '0;
            rr_q       <= '0;
            flit_q     <= '0;
            vcOut_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lockVc_q   <= lockVc_d;
            rr_q       <= rr_d;
            flit_q     <= flit_d;
            vcOut_q    <= vcOut_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign FLIT_out     = flit_q;
    assign VC_out       = vcOut_q;
    assign VALID_out    = valid_q;
    assign overflow_err = overflow_q;

endmodule
